wb_bus_initiator: RTL and testbench
===================================

// Module: wb_bus_initiator
// PURPOSE
//   Wishbone classic initiator: turns one-at-a-time commands into single Wishbone
//   read/write cycles toward the project-select/OEB/project register space
//   (0x3000_0000 region). Used for on-chip bring-up sequencing and as the bench
//   master. Bounded ack wait with timeout/error reporting.
// PARAMETERS
//   TIMEOUT     64   BUS cycles waited for ack before abort (>=2)
//   CNT_WIDTH   16   width of txn_count_o / err_count_o (wrap at 2^CNT_WIDTH)
// PORTS
//   wb_clk_i      in   1   clock; all logic rising-edge
//   rstn_i        in   1   async active-low reset
//   cmd_valid_i   in   1   command present
//   cmd_ready_o   out  1   command accepted when valid&&ready at posedge
//   cmd_we_i      in   1   1=write 0=read
//   cmd_adr_i     in   32  byte address
//   cmd_dat_i     in   32  write data
//   cmd_sel_i     in   4   byte selects
//   rsp_valid_o   out  1   response held until rsp_ready_i
//   rsp_ready_i   in   1   response consumed
//   rsp_dat_o     out  32  read data (0 for writes and timeouts)
//   rsp_err_o     out  1   1=timed out, no ack
//   busy_o        out  1   state != IDLE
//   txn_count_o   out  CNT_WIDTH  completed (acked) cycles
//   err_count_o   out  CNT_WIDTH  timed-out cycles
//   wbm_cyc_o     out  1   Wishbone cycle
//   wbm_stb_o     out  1   Wishbone strobe (always == cyc)
//   wbm_we_o      out  1   write enable
//   wbm_sel_o     out  4   byte selects
//   wbm_adr_o     out  32  address
//   wbm_dat_o     out  32  write data
//   wbm_dat_i     in   32  read data
//   wbm_ack_i     in   1   ack from responder
// BEHAVIOUR
//   Reset (async, rstn_i low): state=IDLE; cyc/stb/we=0, sel/adr/dat_o=0,
//     rsp_valid=0, rsp_dat=0, rsp_err=0, counters=0, timeout ctr=0. cyc/stb drop
//     immediately even mid-cycle; in-flight command lost, no response.
//   FSM: IDLE -> BUS -> RESP -> IDLE. All outputs registered except
//     cmd_ready_o = (state==IDLE) and busy_o = (state!=IDLE).
//   IDLE: on cmd_valid&&cmd_ready latch we/adr/dat/sel onto wbm_*; cyc=stb=1
//     from next cycle; tmo ctr=0; -> BUS. wbm_ack_i ignored in IDLE/RESP.
//   BUS: wbm_* held stable. Each posedge:
//     ack=1 -> cyc=stb=0; rsp_dat = we?0:wbm_dat_i; rsp_err=0; txn_count++; -> RESP
//     else tmo ctr==TIMEOUT-1 -> cyc=stb=0; rsp_dat=0; rsp_err=1; err_count++; -> RESP
//     else tmo ctr++.
//     Ack on same edge as timeout: ack wins (success, no error).
//   Latency: command accept to cyc high = 1 cycle; responder ack sampled at edge N
//     -> rsp_valid high after edge N, cyc low after edge N.
//   RESP: rsp_valid=1, rsp_dat/err stable; on rsp_ready_i -> rsp_valid=0, -> IDLE.
//     Min gap between cycles: cyc low >=2 clocks (RESP + IDLE), so a responder
//     holding ack one extra clock after stb drop is not misread.
//   Counters wrap to 0 past all-ones; no saturation.
//   wbm_adr_o/dat_o/sel_o/we_o keep last values after cycle end (don't-care when cyc=0).
// TESTING
//   1 write 0x3000_0000 dat=0x05 sel=0xF, responder acks 2 clks after stb ->
//     cyc high 3 clks, rsp_valid with err=0 dat=0, txn_count=1.
//   2 read 0x3000_0000 after test 1, responder returns 0x05 -> rsp_dat=0x0000_0005,
//     err=0; read unmapped 0x3000_0300 (no ack) -> cyc drops after exactly
//     TIMEOUT clks, rsp_err=1, rsp_dat=0, err_count=1.
//   3 ack asserted on timeout edge (clk TIMEOUT of BUS) -> err=0, txn_count++, err_count unchanged.
//   4 rsp_ready held low 10 clks -> rsp_valid/dat stable, cmd_ready=0, cyc=0
//     throughout; stray ack pulses ignored; next command accepted only after rsp_ready.
//   5 rstn_i low mid-BUS (async, between edges) -> cyc/stb low before next edge,
//     rsp_valid=0, counters=0, cmd_ready=1 after release.
//   6 set txn_count to 0xFFFF via 65535 acked writes (CNT_WIDTH=16) + 1 more -> txn_count=0.

Source files
------------

// File: rtl/wb_bus_initiator.sv
// Wishbone classic single-cycle initiator: one command in, one bus cycle out, one response back.
// The wait for an ack is bounded, and cycles that get no ack are reported as errors.
module wb_bus_initiator #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 rstn_i,
  // command side
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [31:0]          cmd_adr_i,
  input  logic [31:0]          cmd_dat_i,
  input  logic [3:0]           cmd_sel_i,
  // response side
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_dat_o,
  output logic                 rsp_err_o,
  // status
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] txn_count_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  // wishbone master
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CNT_WIDTH-1:0] txn_cnt_q, txn_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;

  always_ff @(posedge wb_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      txn_cnt_q   <= '0;
      err_cnt_q   <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_cnt_q   <= txn_cnt_d;
      err_cnt_q   <= err_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_cnt_d   = txn_cnt_q;
    err_cnt_d   = err_cnt_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          tmo_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // An ack arriving on the timeout edge still counts as success.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          txn_cnt_d   = txn_cnt_q + CNT_WIDTH'(1);
          state_d     = StResp;
        end else if (tmo_q == TmoLast) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          err_cnt_d   = err_cnt_q + CNT_WIDTH'(1);
          state_d     = StResp;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign txn_count_o = txn_cnt_q;
  assign err_count_o = err_cnt_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_bus_initiator.sv
// Directed bench for wb_bus_initiator; the counter width is narrowed so that
// counter wrap-around can be reached in a short run.
module tb_wb_bus_initiator;
  localparam int unsigned Tmo = 64;
  localparam int unsigned Cw  = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0]   cmd_adr = '0, cmd_dat = '0;
  logic [3:0]    cmd_sel = '0;
  logic          rsp_ready = 1'b0;
  logic [31:0]   wb_rdat = '0;
  logic          wb_ack = 1'b0;
  logic          cmd_ready, rsp_valid, rsp_err, busy;
  logic [31:0]   rsp_dat;
  logic [Cw-1:0] txn_count, err_count;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_bus_initiator #(.TIMEOUT(Tmo), .CNT_WIDTH(Cw)) dut (
    .wb_clk_i(clk), .rstn_i(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .busy_o(busy), .txn_count_o(txn_count), .err_count_o(err_count),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(wb_rdat), .wbm_ack_i(wb_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one command and returns just after the edge that accepted it.
  task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_wait cmd_ready=%b required 1", cmd_ready);
    end
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic quick_write;
    cmd_we = 1'b1; cmd_adr = 32'h3000_0010; cmd_dat = 32'h1; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rstn = 1'b0;
    tick();
    tick();
    total++;
    if ({cyc, stb, we, sel, adr, wdat, rsp_valid, rsp_dat, rsp_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs cyc=%b stb=%b rsp_valid=%b adr=%h required all zero",
               cyc, stb, rsp_valid, adr);
    end
    total++;
    if (txn_count !== '0 || err_count !== '0) begin
      bad++;
      $display("FAIL reset_counts txn=%h err=%h required 0/0", txn_count, err_count);
    end
    #2 rstn = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write;
    issue_cmd(1'b1, 32'h3000_0000, 32'h0000_0005, 4'hF);
    total++;
    if ({cyc, stb, we, busy, cmd_ready} !== 5'b11110) begin
      bad++;
      $display("FAIL wr_start cyc/stb/we/busy/rdy=%b required 11110",
               {cyc, stb, we, busy, cmd_ready});
    end
    total++;
    if (adr !== 32'h3000_0000 || wdat !== 32'h5 || sel !== 4'hF) begin
      bad++;
      $display("FAIL wr_bus adr=%h dat=%h sel=%h required 30000000/5/f", adr, wdat, sel);
    end
    tick();
    tick();
    total++;
    if (cyc !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL wr_hold cyc=%b rsp_valid=%b required 1/0", cyc, rsp_valid);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    total++;
    if ({cyc, stb, rsp_valid, rsp_err} !== 4'b0010 || rsp_dat !== 32'h0 || txn_count !== Cw'(1)) begin
      bad++;
      $display("FAIL wr_resp cyc=%b valid=%b err=%b dat=%h txn=%0d required 0/1/0/0/1",
               cyc, rsp_valid, rsp_err, rsp_dat, txn_count);
    end
    consume();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_done rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_timeout;
    int n;
    issue_cmd(1'b0, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF);
    wb_ack = 1'b1; wb_rdat = 32'h0000_0005;
    tick();
    wb_ack = 1'b0; wb_rdat = 32'h0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h5 || txn_count !== Cw'(2)) begin
      bad++;
      $display("FAIL rd_resp valid=%b err=%b dat=%h txn=%0d required 1/0/5/2",
               rsp_valid, rsp_err, rsp_dat, txn_count);
    end
    consume();
    issue_cmd(1'b0, 32'h3000_0300, 32'h0, 4'hF);
    n = 0;
    while (cyc && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n !== Tmo) begin
      bad++;
      $display("FAIL tmo_len cyc_clocks=%0d required %0d", n, Tmo);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin
      bad++;
      $display("FAIL tmo_resp valid=%b err=%b dat=%h required 1/1/0", rsp_valid, rsp_err, rsp_dat);
    end
    total++;
    if (err_count !== Cw'(1) || txn_count !== Cw'(2)) begin
      bad++;
      $display("FAIL tmo_counts err=%0d txn=%0d required 1/2", err_count, txn_count);
    end
    consume();
  endtask

  task automatic test_ack_on_timeout;
    issue_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    for (int i = 0; i < Tmo - 1; i++) tick();
    wb_ack = 1'b1; wb_rdat = 32'hA5A5_0001;
    tick();
    wb_ack = 1'b0; wb_rdat = 32'h0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL edge_resp valid=%b err=%b dat=%h required 1/0/a5a50001",
               rsp_valid, rsp_err, rsp_dat);
    end
    total++;
    if (txn_count !== Cw'(3) || err_count !== Cw'(1)) begin
      bad++;
      $display("FAIL edge_counts txn=%0d err=%0d required 3/1", txn_count, err_count);
    end
    consume();
  endtask

  task automatic test_resp_stall;
    issue_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    wb_ack = 1'b1; wb_rdat = 32'h1234_5678;
    tick();
    wb_ack = 1'b0;
    cmd_we = 1'b1; cmd_adr = 32'h3000_0008; cmd_dat = 32'h77; cmd_sel = 4'h3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wb_ack = i[0];
      wb_rdat = 32'hFFFF_0000 + i;
      tick();
      total++;
      if ({rsp_valid, rsp_err, cmd_ready, cyc} !== 4'b1000 || rsp_dat !== 32'h1234_5678) begin
        bad++;
        $display("FAIL stall_%0d valid/err/rdy/cyc=%b dat=%h required 1000/12345678",
                 i, {rsp_valid, rsp_err, cmd_ready, cyc}, rsp_dat);
      end
    end
    wb_ack = 1'b0;
    total++;
    if (txn_count !== Cw'(4) || err_count !== Cw'(1)) begin
      bad++;
      $display("FAIL stall_counts txn=%0d err=%0d required 4/1", txn_count, err_count);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (cmd_ready !== 1'b1 || cyc !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release rdy=%b cyc=%b valid=%b required 1/0/0", cmd_ready, cyc, rsp_valid);
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if (cyc !== 1'b1 || adr !== 32'h3000_0008 || we !== 1'b1 || sel !== 4'h3) begin
      bad++;
      $display("FAIL stall_next cyc=%b adr=%h we=%b sel=%h required 1/30000008/1/3",
               cyc, adr, we, sel);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    total++;
    if (txn_count !== Cw'(5)) begin
      bad++;
      $display("FAIL stall_txn txn=%0d required 5", txn_count);
    end
    consume();
  endtask

  task automatic test_async_reset;
    issue_cmd(1'b1, 32'h3000_000C, 32'h9, 4'hF);
    tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({cyc, stb, rsp_valid, busy} !== 4'b0000 || txn_count !== '0 || err_count !== '0) begin
      bad++;
      $display("FAIL areset cyc/stb/valid/busy=%b txn=%0d err=%0d required 0000/0/0",
               {cyc, stb, rsp_valid, busy}, txn_count, err_count);
    end
    #2 rstn = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || cyc !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL areset_release rdy=%b cyc=%b valid=%b required 1/0/0", cmd_ready, cyc, rsp_valid);
    end
  endtask

  task automatic test_back_to_back_wrap;
    for (int i = 0; i < (1 << Cw) - 1; i++) quick_write();
    total++;
    if (txn_count !== {Cw{1'b1}}) begin
      bad++;
      $display("FAIL wrap_full txn=%h required %h", txn_count, {Cw{1'b1}});
    end
    quick_write();
    total++;
    if (txn_count !== '0 || err_count !== '0) begin
      bad++;
      $display("FAIL wrap_zero txn=%h err=%h required 0/0", txn_count, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_timeout();
    test_ack_on_timeout();
    test_resp_stall();
    test_async_reset();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
